// File: rtl/speech_sequencer.sv
// Utterance sequencer: latches mood/action/stage on start and streams speech-ROM
// addresses over valid/ready, with an optional gap between words and LFSR babble at stage 0.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// PLAN  | one cycle to size the utterance from the latched stage
// EMIT  | presenting a word address, waiting for addr_ready
// GAP   | addr_valid low for GAP_CYCLES cycles between words
module speech_sequencer #(
  parameter int ADDR_WIDTH   = 13,
  parameter int STATE_WIDTH  = 8,
  parameter int ACTION_WIDTH = 8,
  parameter int STAGE_BITS   = 2,
  parameter int MOOD_BITS    = 2,
  parameter int MAX_WORDS    = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BABBLE_BASE  = 4096,
  parameter int BABBLE_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [STATE_WIDTH-1:0]  emotional_state,
  input  logic [ACTION_WIDTH-1:0] action,
  input  logic [STAGE_BITS-1:0]   development_stage,
  input  logic                    start,
  input  logic                    addr_ready,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    addr_valid,
  output logic                    last,
  output logic                    busy
);

  localparam int IDX_BITS = $clog2(MAX_WORDS);
  localparam int CNT_BITS = IDX_BITS + 1;
  localparam int PLAN_W   = MOOD_BITS + ACTION_WIDTH + IDX_BITS;
  localparam int GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PLAN, EMIT, GAP} state_t;

  state_t                  state, state_nxt;
  logic [MOOD_BITS-1:0]    mood_q;
  logic [ACTION_WIDTH-1:0] action_q;
  logic [STAGE_BITS-1:0]   stage_q;
  logic [CNT_BITS-1:0]     word_count;
  logic [IDX_BITS-1:0]     word_idx;
  logic [GAP_BITS-1:0]     gap_cnt;
  logic [7:0]              lfsr;

  logic                    handshake;
  logic                    is_last;
  logic                    babble;
  logic [CNT_BITS-1:0]     plan_count;
  logic [PLAN_W-1:0]       plan_addr;
  logic [ADDR_WIDTH-1:0]   babble_addr;
  logic                    unused_es;

  assign unused_es   = ^emotional_state[STATE_WIDTH-MOOD_BITS-1:0];
  assign babble      = (stage_q == '0);
  assign handshake   = (state == EMIT) && addr_ready;
  assign is_last     = ({1'b0, word_idx} == word_count - CNT_BITS'(1));
  assign plan_addr   = {mood_q, action_q, word_idx};
  assign babble_addr = ADDR_WIDTH'(BABBLE_BASE) + ADDR_WIDTH'(lfsr[BABBLE_BITS-1:0]);

  // Babble utterances are always two words; planned ones grow with maturity.
  always_comb begin
    plan_count = CNT_BITS'(MAX_WORDS);
    if (stage_q == '0) begin
      plan_count = CNT_BITS'(2);
    end else if (32'(stage_q) + 32'd1 < 32'(MAX_WORDS)) begin
      plan_count = CNT_BITS'(32'(stage_q) + 32'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PLAN;
      PLAN: state_nxt = EMIT;
      EMIT: begin
        if (handshake) begin
          if (is_last) begin
            state_nxt = IDLE;
          end else if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
          end
        end
      end
      GAP: if (gap_cnt == '0) state_nxt = EMIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      mood_q     <= '0;
      action_q   <= '0;
      stage_q    <= '0;
      word_count <= '0;
      word_idx   <= '0;
      gap_cnt    <= '0;
      lfsr       <= 8'hA5;
    end else begin
      if (state == IDLE && start) begin
        mood_q   <= emotional_state[STATE_WIDTH-1 -: MOOD_BITS];
        action_q <= action;
        stage_q  <= development_stage;
      end
      if (state == PLAN) begin
        word_count <= plan_count;
        word_idx   <= '0;
      end
      if (handshake && !is_last) begin
        word_idx <= word_idx + IDX_BITS'(1);
        if (GAP_CYCLES > 0) begin
          gap_cnt <= GAP_BITS'(GAP_CYCLES - 1);
        end
      end
      if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_BITS'(1);
      end
      // The babble source only moves when a babble word is consumed, so it carries over utterances.
      if (handshake && babble) begin
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
    end
  end

  always_comb begin
    address    = '0;
    addr_valid = 1'b0;
    last       = 1'b0;
    busy       = (state != IDLE);
    if (state == EMIT) begin
      addr_valid = 1'b1;
      last       = is_last;
      address    = babble ? babble_addr : ADDR_WIDTH'(plan_addr);
    end
  end

endmodule
